hazard_unit: RTL and testbench
==============================

Name: hazard_unit

Overview:
- Stall/flush controller for the 5-stage pipeline; the control-side counterpart of the forwarding unit.
- Forwarding resolves what it can by bypassing. This block handles what bypassing cannot: load-use, memory wait, taken branch/jump, halt.
- Drives per-stage latch enables and flushes plus the PC enable.
- Holds registered state (FSM, bubble counter, deferred-flush flag), so decisions survive multi-cycle memory stalls.

Parameters:
- LU_BUBBLES, 1, number of bubbles inserted on a load-use hazard (1..3).
- CNT_W, 32, width of the statistics counters (optional feature only).

Ports:
- CLK  input  1  clock
- nRST  input  1  asynchronous active-low reset
- ihit  input  1  instruction fetch completed this cycle
- dhit  input  1  data access completed this cycle
- id_rs  input  5 (regbits_t)  rs of the instruction in ID
- id_rt  input  5 (regbits_t)  rt of the instruction in ID
- id_uses_rt  input  1  ID instruction reads rt
- ex_writeReg  input  5 (regbits_t)  destination register of the EX instruction
- ex_dmemREN  input  1  EX instruction is a load
- mem_dmemREN  input  1  MEM-stage load
- mem_dmemWEN  input  1  MEM-stage store
- ex_pcsrc  input  1  taken branch/jump resolved in EX
- wb_halt  input  1  halt instruction reached WB
- pc_en  output  1  PC update enable
- ifid_en  output  1  IF/ID latch enable
- ifid_flush  output  1  IF/ID flush
- idex_en  output  1  ID/EX latch enable
- idex_flush  output  1  ID/EX flush
- exmem_en  output  1  EX/MEM latch enable
- memwb_en  output  1  MEM/WB latch enable
- halted  output  1  sticky halt indication

Behaviour:
- Reset: async on nRST low.
  - state=RUN, bub_cnt=0, flush_pend=0, halted=0.
  - While nRST is low, all enables=0 and all flushes=0.
- dwait = (mem_dmemREN|mem_dmemWEN) & ~dhit.
- adv = ihit & ~dwait.
- lu = ex_dmemREN & (ex_writeReg!=0) & (ex_writeReg==id_rs | (id_uses_rt & ex_writeReg==id_rt)).
- Outputs are combinational from state plus inputs. State updates on posedge CLK.
- RUN:
  - Default: all enables = adv, flushes=0.
  - If ex_pcsrc & adv: pc_en=1, ifid_flush=1, idex_flush=1.
  - If ex_pcsrc & ~adv: set flush_pend.
  - Else if lu & adv: pc_en=0, ifid_en=0, idex_flush=1, exmem_en=memwb_en=1. If LU_BUBBLES>1, go to BUBBLE with bub_cnt=LU_BUBBLES-1.
  - Else if dwait: go to MEMWAIT.
- BUBBLE:
  - pc_en=ifid_en=0, idex_flush=adv, downstream enables = adv.
  - bub_cnt decrements on adv; return to RUN when it reaches 0 on an adv cycle.
- MEMWAIT:
  - All enables=0, no flushes.
  - On dhit: return to RUN and take RUN's decisions in that same cycle.
- flush_pend: on the first adv cycle, assert ifid_flush and idex_flush, pc_en=1, then clear. It takes priority over lu.
- Priority: halt > ex_pcsrc/flush_pend > lu > dwait.
- wb_halt: go to HALTED at the next edge. In HALTED all enables=0 and halted=1 until reset.
- A flush never occurs without its latch advancing. Writes to register 0 never cause a stall.

Optional Feature:
- Macro: HAZARD_STATS_EN.
- Defined: three CNT_W counters (lu_stalls, mem_stall_cycles, flushes) plus output ports stat_lu, stat_mem, stat_flush.
  - Counters reset to 0 and saturate at all-ones.
  - They count cycles in which the respective condition drives an enable low or a flush high.
- Undefined: counters and ports are absent; behaviour is otherwise identical.

Decomposition:
- cpu_types_pkg holds the hazard_state_t enum (RUN, BUBBLE, MEMWAIT, HALTED); regbits_t is reused.
- A hazard_if interface with hz (block) and tb modports.
- No sub-module. The stats counters are a generate/ifdef block inside the module.

Test Plan:
- lw $5 in EX, ID reads rs=$5, ihit=1, dhit=1 -> one cycle of pc_en=0, ifid_en=0, idex_flush=1, then normal flow.
- Same, with ex_writeReg=0 -> no stall.
- Store in MEM with dhit low for 3 cycles -> MEMWAIT; all enables 0 for 3 cycles; released in the dhit cycle.
- ex_pcsrc=1 while ihit=0 for 2 cycles -> no flush during the wait; ifid_flush and idex_flush high in the first ihit cycle, then low.
- LU_BUBBLES=2, load-use -> two bubble cycles, bub_cnt 1->0, back to RUN.
- wb_halt=1 -> halted=1 from the next cycle; enables stay 0 until nRST pulses low mid-run, which restores RUN. With HAZARD_STATS_EN, the counters read 0 after reset.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared pipeline types: register index, hazard controller states and the
// bundle of latch-control bits the hazard unit drives.
package cpu_types_pkg;

  typedef logic [4:0] regbits_t;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    BUBBLE  = 2'd1,
    MEMWAIT = 2'd2,
    HALTED  = 2'd3
  } hazard_state_t;

  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic ifid_flush;
    logic idex_en;
    logic idex_flush;
    logic exmem_en;
    logic memwb_en;
  } hz_ctrl_t;

  // All latch enables tied to one value, flushes cleared.
  function automatic hz_ctrl_t ctrlAll(input logic en);
    hz_ctrl_t c;
    c.pc_en      = en;
    c.ifid_en    = en;
    c.ifid_flush = 1'b0;
    c.idex_en    = en;
    c.idex_flush = 1'b0;
    c.exmem_en   = en;
    c.memwb_en   = en;
    return c;
  endfunction

endpackage

// File: rtl/hazard_if.sv
// Pipeline-status inputs and stall/flush outputs of the hazard unit.
// Modport hz is the hazard unit side, tb the driving side.
interface hazard_if;
  import cpu_types_pkg::*;

  logic     ihit;
  logic     dhit;
  regbits_t id_rs;
  regbits_t id_rt;
  logic     id_uses_rt;
  regbits_t ex_writeReg;
  logic     ex_dmemREN;
  logic     mem_dmemREN;
  logic     mem_dmemWEN;
  logic     ex_pcsrc;
  logic     wb_halt;

  logic     pc_en;
  logic     ifid_en;
  logic     ifid_flush;
  logic     idex_en;
  logic     idex_flush;
  logic     exmem_en;
  logic     memwb_en;
  logic     halted;

  modport hz (
    input  ihit, dhit, id_rs, id_rt, id_uses_rt, ex_writeReg, ex_dmemREN,
           mem_dmemREN, mem_dmemWEN, ex_pcsrc, wb_halt,
    output pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en,
           memwb_en, halted
  );

  modport tb (
    output ihit, dhit, id_rs, id_rt, id_uses_rt, ex_writeReg, ex_dmemREN,
           mem_dmemREN, mem_dmemWEN, ex_pcsrc, wb_halt,
    input  pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en,
           memwb_en, halted
  );

endinterface

// File: rtl/hazard_unit.sv
// Stall/flush controller for the 5-stage pipeline (load-use, memory wait,
// taken branch, halt). Define HAZARD_STATS_EN to add saturating event counters.
module hazard_unit
  import cpu_types_pkg::*;
#(
  parameter int LU_BUBBLES = 1
`ifdef HAZARD_STATS_EN
  ,
  parameter int CNT_W = 32
`endif
) (
  input  logic CLK,
  input  logic nRST,
  hazard_if.hz hzif
`ifdef HAZARD_STATS_EN
  ,
  output logic [CNT_W-1:0] stat_lu,
  output logic [CNT_W-1:0] stat_mem,
  output logic [CNT_W-1:0] stat_flush
`endif
);

  localparam logic [1:0] LU_RELOAD = 2'(LU_BUBBLES - 1);

  hazard_state_t state_r;
  hazard_state_t stateRule_s;
  hazard_state_t stateNxt_s;
  logic [1:0]    bubCnt_r;
  logic [1:0]    bubCntNxt_s;
  logic          flushPend_r;
  logic          flushPendNxt_s;
  logic          dwait_s;
  logic          adv_s;
  logic          lu_s;
  logic          flushReq_s;
  hz_ctrl_t      ctrl_s;

  assign dwait_s    = (hzif.mem_dmemREN | hzif.mem_dmemWEN) & ~hzif.dhit;
  assign adv_s      = hzif.ihit & ~dwait_s;
  assign lu_s       = hzif.ex_dmemREN & (hzif.ex_writeReg != 5'd0) &
                      ((hzif.ex_writeReg == hzif.id_rs) |
                       (hzif.id_uses_rt & (hzif.ex_writeReg == hzif.id_rt)));
  assign flushReq_s = hzif.ex_pcsrc | flushPend_r;

  // Next-state and latch-control decisions; halt overrides the state below.
  always_comb begin
    ctrl_s         = ctrlAll(1'b0);
    stateRule_s    = state_r;
    bubCntNxt_s    = bubCnt_r;
    flushPendNxt_s = flushPend_r;
    case (state_r)
      RUN, MEMWAIT: begin
        if ((state_r == MEMWAIT) && !hzif.dhit) begin
          ctrl_s = ctrlAll(1'b0);
        end else begin
          // Leaving MEMWAIT on dhit makes the same decisions as RUN.
          ctrl_s      = ctrlAll(adv_s);
          stateRule_s = RUN;
          if (flushReq_s && adv_s) begin
            ctrl_s.pc_en      = 1'b1;
            ctrl_s.ifid_flush = 1'b1;
            ctrl_s.idex_flush = 1'b1;
            flushPendNxt_s    = 1'b0;
          end else if (lu_s && adv_s) begin
            ctrl_s.pc_en      = 1'b0;
            ctrl_s.ifid_en    = 1'b0;
            ctrl_s.idex_flush = 1'b1;
            if (LU_BUBBLES > 1) begin
              stateRule_s = BUBBLE;
              bubCntNxt_s = LU_RELOAD;
            end else begin
              stateRule_s = RUN;
            end
          end else begin
            flushPendNxt_s = flushPend_r | hzif.ex_pcsrc;
            stateRule_s    = dwait_s ? MEMWAIT : RUN;
          end
        end
      end
      BUBBLE: begin
        ctrl_s.idex_en    = adv_s;
        ctrl_s.idex_flush = adv_s;
        ctrl_s.exmem_en   = adv_s;
        ctrl_s.memwb_en   = adv_s;
        if (adv_s) begin
          bubCntNxt_s = bubCnt_r - 2'd1;
          stateRule_s = (bubCnt_r == 2'd1) ? RUN : BUBBLE;
        end else begin
          bubCntNxt_s = bubCnt_r;
        end
      end
      HALTED: begin
        ctrl_s = ctrlAll(1'b0);
      end
      default: begin
        stateRule_s = RUN;
      end
    endcase
  end

  assign stateNxt_s = hzif.wb_halt ? HALTED : stateRule_s;

  // Controller state register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_r     <= RUN;
      bubCnt_r    <= 2'd0;
      flushPend_r <= 1'b0;
    end else begin
      state_r     <= stateNxt_s;
      bubCnt_r    <= bubCntNxt_s;
      flushPend_r <= flushPendNxt_s;
    end
  end

  // Everything is held quiet while reset is asserted.
  assign hzif.pc_en      = ctrl_s.pc_en      & nRST;
  assign hzif.ifid_en    = ctrl_s.ifid_en    & nRST;
  assign hzif.ifid_flush = ctrl_s.ifid_flush & nRST;
  assign hzif.idex_en    = ctrl_s.idex_en    & nRST;
  assign hzif.idex_flush = ctrl_s.idex_flush & nRST;
  assign hzif.exmem_en   = ctrl_s.exmem_en   & nRST;
  assign hzif.memwb_en   = ctrl_s.memwb_en   & nRST;
  assign hzif.halted     = (state_r == HALTED);

`ifdef HAZARD_STATS_EN
  logic luEv_s;
  logic memEv_s;
  logic flushEv_s;
  logic [CNT_W-1:0] luCnt_r;
  logic [CNT_W-1:0] memCnt_r;
  logic [CNT_W-1:0] flushCnt_r;

  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v, input logic ev);
    return (ev && (v != {CNT_W{1'b1}})) ? v + {{(CNT_W-1){1'b0}}, 1'b1} : v;
  endfunction

  // Load-use bubbles flush ID/EX without touching IF/ID; branches flush both.
  assign luEv_s    = (state_r == BUBBLE) | (ctrl_s.idex_flush & ~ctrl_s.ifid_flush);
  assign memEv_s   = dwait_s & (state_r != HALTED);
  assign flushEv_s = ctrl_s.ifid_flush;

  // Saturating statistics counters.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      luCnt_r    <= {CNT_W{1'b0}};
      memCnt_r   <= {CNT_W{1'b0}};
      flushCnt_r <= {CNT_W{1'b0}};
    end else begin
      luCnt_r    <= satInc(luCnt_r, luEv_s);
      memCnt_r   <= satInc(memCnt_r, memEv_s);
      flushCnt_r <= satInc(flushCnt_r, flushEv_s);
    end
  end

  assign stat_lu    = luCnt_r;
  assign stat_mem   = memCnt_r;
  assign stat_flush = flushCnt_r;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed scenarios plus random stimulus
// against a behavioural model, run on LU_BUBBLES=1 (A) and LU_BUBBLES=2 (B).
module tb_hazard_unit;
  import cpu_types_pkg::*;

  logic CLK = 1'b0;
  logic nRST = 1'b0;
  always #5 CLK = ~CLK;

  logic     ihit, dhit, idUsesRt, exDmemREN, memDmemREN, memDmemWEN, exPcsrc, wbHalt;
  regbits_t idRs, idRt, exWriteReg;

  int nCmp = 0;
  int nErr = 0;

  hazard_if hzA();
  hazard_if hzB();

  assign hzA.ihit = ihit;           assign hzB.ihit = ihit;
  assign hzA.dhit = dhit;           assign hzB.dhit = dhit;
  assign hzA.id_rs = idRs;          assign hzB.id_rs = idRs;
  assign hzA.id_rt = idRt;          assign hzB.id_rt = idRt;
  assign hzA.id_uses_rt = idUsesRt; assign hzB.id_uses_rt = idUsesRt;
  assign hzA.ex_writeReg = exWriteReg; assign hzB.ex_writeReg = exWriteReg;
  assign hzA.ex_dmemREN = exDmemREN;   assign hzB.ex_dmemREN = exDmemREN;
  assign hzA.mem_dmemREN = memDmemREN; assign hzB.mem_dmemREN = memDmemREN;
  assign hzA.mem_dmemWEN = memDmemWEN; assign hzB.mem_dmemWEN = memDmemWEN;
  assign hzA.ex_pcsrc = exPcsrc;    assign hzB.ex_pcsrc = exPcsrc;
  assign hzA.wb_halt = wbHalt;      assign hzB.wb_halt = wbHalt;

`ifdef HAZARD_STATS_EN
  logic [31:0] sLuA, sMemA, sFlA, sLuB, sMemB, sFlB;
  hazard_unit #(.LU_BUBBLES(1), .CNT_W(32)) dutA (.CLK(CLK), .nRST(nRST), .hzif(hzA),
    .stat_lu(sLuA), .stat_mem(sMemA), .stat_flush(sFlA));
  hazard_unit #(.LU_BUBBLES(2), .CNT_W(32)) dutB (.CLK(CLK), .nRST(nRST), .hzif(hzB),
    .stat_lu(sLuB), .stat_mem(sMemB), .stat_flush(sFlB));
`else
  hazard_unit #(.LU_BUBBLES(1)) dutA (.CLK(CLK), .nRST(nRST), .hzif(hzA));
  hazard_unit #(.LU_BUBBLES(2)) dutB (.CLK(CLK), .nRST(nRST), .hzif(hzB));
`endif

  // Packed view: {halted, pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en}
  localparam logic [7:0] P_RUN   = 8'h6B;
  localparam logic [7:0] P_LU    = 8'h0F;
  localparam logic [7:0] P_FLUSH = 8'h7F;
  localparam logic [7:0] P_OFF   = 8'h00;
  localparam logic [7:0] P_HALT  = 8'h80;

  function automatic logic [15:0] obsAB();
    return {hzA.halted, hzA.pc_en, hzA.ifid_en, hzA.ifid_flush, hzA.idex_en,
            hzA.idex_flush, hzA.exmem_en, hzA.memwb_en,
            hzB.halted, hzB.pc_en, hzB.ifid_en, hzB.ifid_flush, hzB.idex_en,
            hzB.idex_flush, hzB.exmem_en, hzB.memwb_en};
  endfunction

  // Behavioural model: bubbles still owed, waiting on memory, pending flush, halted.
  int mBub [2];
  bit mWait[2];
  bit mPend[2];
  bit mHalt[2];
  int nbOf [2] = '{1, 2};

  function automatic bit curDwait();
    return (memDmemREN || memDmemWEN) && !dhit;
  endfunction

  function automatic bit curLu();
    return exDmemREN && (exWriteReg != 5'd0) &&
           ((exWriteReg == idRs) || (idUsesRt && (exWriteReg == idRt)));
  endfunction

  function automatic logic [7:0] modelOut(input int k);
    bit ad;
    ad = ihit && !curDwait();
    if (mHalt[k])              return P_HALT;
    if (mBub[k] > 0)           return ad ? P_LU : P_OFF;
    if (mWait[k] && !dhit)     return P_OFF;
    if (!ad)                   return P_OFF;
    if (exPcsrc || mPend[k])   return P_FLUSH;
    if (curLu())               return P_LU;
    return P_RUN;
  endfunction

  task automatic modelClock(input int k);
    bit ad;
    ad = ihit && !curDwait();
    if (wbHalt) begin
      mHalt[k] = 1'b1;
    end else if (mHalt[k]) begin
      mHalt[k] = 1'b1;
    end else if (mBub[k] > 0) begin
      if (ad) mBub[k] = mBub[k] - 1;
    end else if (mWait[k] && !dhit) begin
      mWait[k] = 1'b1;
    end else begin
      mWait[k] = 1'b0;
      if ((exPcsrc || mPend[k]) && ad) mPend[k] = 1'b0;
      else if (curLu() && ad)          mBub[k] = nbOf[k] - 1;
      else begin
        if (exPcsrc)    mPend[k] = 1'b1;
        if (curDwait()) mWait[k] = 1'b1;
      end
    end
  endtask

  task automatic modelReset();
    for (int k = 0; k < 2; k++) begin
      mBub[k] = 0; mWait[k] = 1'b0; mPend[k] = 1'b0; mHalt[k] = 1'b0;
    end
  endtask

  task automatic setIdle();
    ihit = 1'b1; dhit = 1'b1; idUsesRt = 1'b0; exDmemREN = 1'b0;
    memDmemREN = 1'b0; memDmemWEN = 1'b0; exPcsrc = 1'b0; wbHalt = 1'b0;
    idRs = 5'd7; idRt = 5'd8; exWriteReg = 5'd9;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    setIdle();
    nRST = 1'b0;
    @(negedge CLK);
    nCmp++;
    if (obsAB() !== {P_OFF, P_OFF}) begin
      nErr++; $display("FAIL reset_hold: got %h want %h", obsAB(), {P_OFF, P_OFF});
    end
    tick();
    nRST = 1'b1;
    @(negedge CLK);
    nCmp++;
    if (obsAB() !== {P_RUN, P_RUN}) begin
      nErr++; $display("FAIL reset_release: got %h want %h", obsAB(), {P_RUN, P_RUN});
    end
  endtask

  task automatic test_load_use();
    logic [7:0] expB [3] = '{P_LU, P_LU, P_RUN};
    logic [7:0] expA [3] = '{P_LU, P_RUN, P_RUN};
    tick();
    exDmemREN = 1'b1; exWriteReg = 5'd5; idRs = 5'd5;
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      nCmp++;
      if (obsAB() !== {expA[c], expB[c]}) begin
        nErr++; $display("FAIL load_use_c%0d: got %h want %h", c, obsAB(), {expA[c], expB[c]});
      end
      tick();
      exDmemREN = 1'b0; idRs = 5'd7;
    end
    // rt dependence counts only when ID actually reads rt
    exDmemREN = 1'b1; exWriteReg = 5'd6; idRt = 5'd6; idUsesRt = 1'b0;
    @(negedge CLK);
    nCmp++;
    if (obsAB() !== {P_RUN, P_RUN}) begin
      nErr++; $display("FAIL lu_rt_unused: got %h want %h", obsAB(), {P_RUN, P_RUN});
    end
    tick();
    idUsesRt = 1'b1;
    @(negedge CLK);
    nCmp++;
    if (obsAB() !== {P_LU, P_LU}) begin
      nErr++; $display("FAIL lu_rt_used: got %h want %h", obsAB(), {P_LU, P_LU});
    end
    tick();
    setIdle();
    tick();
  endtask

  task automatic test_reg_zero();
    exDmemREN = 1'b1; exWriteReg = 5'd0; idRs = 5'd0; idRt = 5'd0; idUsesRt = 1'b1;
    @(negedge CLK);
    nCmp++;
    if (obsAB() !== {P_RUN, P_RUN}) begin
      nErr++; $display("FAIL reg_zero: got %h want %h", obsAB(), {P_RUN, P_RUN});
    end
    tick();
    setIdle();
  endtask

  task automatic test_mem_wait();
    memDmemWEN = 1'b1; dhit = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      nCmp++;
      if (obsAB() !== {P_OFF, P_OFF}) begin
        nErr++; $display("FAIL mem_wait_c%0d: got %h want %h", c, obsAB(), {P_OFF, P_OFF});
      end
      tick();
    end
    dhit = 1'b1;
    @(negedge CLK);
    nCmp++;
    if (obsAB() !== {P_RUN, P_RUN}) begin
      nErr++; $display("FAIL mem_release: got %h want %h", obsAB(), {P_RUN, P_RUN});
    end
    tick();
    setIdle();
  endtask

  task automatic test_branch();
    exPcsrc = 1'b1; ihit = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge CLK);
      nCmp++;
      if (obsAB() !== {P_OFF, P_OFF}) begin
        nErr++; $display("FAIL branch_wait_c%0d: got %h want %h", c, obsAB(), {P_OFF, P_OFF});
      end
      tick();
    end
    // EX has moved on; only the remembered flush remains
    ihit = 1'b1; exPcsrc = 1'b0;
    @(negedge CLK);
    nCmp++;
    if (obsAB() !== {P_FLUSH, P_FLUSH}) begin
      nErr++; $display("FAIL branch_deferred: got %h want %h", obsAB(), {P_FLUSH, P_FLUSH});
    end
    tick();
    @(negedge CLK);
    nCmp++;
    if (obsAB() !== {P_RUN, P_RUN}) begin
      nErr++; $display("FAIL branch_after: got %h want %h", obsAB(), {P_RUN, P_RUN});
    end
    tick();
    // A taken branch outranks a simultaneous load-use
    exPcsrc = 1'b1; exDmemREN = 1'b1; exWriteReg = 5'd3; idRs = 5'd3;
    @(negedge CLK);
    nCmp++;
    if (obsAB() !== {P_FLUSH, P_FLUSH}) begin
      nErr++; $display("FAIL branch_over_lu: got %h want %h", obsAB(), {P_FLUSH, P_FLUSH});
    end
    tick();
    setIdle();
  endtask

  task automatic test_halt();
    wbHalt = 1'b1;
    tick();
    wbHalt = 1'b0;
    for (int c = 0; c < 3; c++) begin
      exPcsrc = c[0];
      @(negedge CLK);
      nCmp++;
      if (obsAB() !== {P_HALT, P_HALT}) begin
        nErr++; $display("FAIL halted_c%0d: got %h want %h", c, obsAB(), {P_HALT, P_HALT});
      end
      tick();
    end
    setIdle();
    nRST = 1'b0;
    @(negedge CLK);
    nCmp++;
    if (obsAB() !== {P_OFF, P_OFF}) begin
      nErr++; $display("FAIL halt_reset: got %h want %h", obsAB(), {P_OFF, P_OFF});
    end
    tick();
    nRST = 1'b1;
    @(negedge CLK);
    nCmp++;
    if (obsAB() !== {P_RUN, P_RUN}) begin
      nErr++; $display("FAIL halt_restart: got %h want %h", obsAB(), {P_RUN, P_RUN});
    end
`ifdef HAZARD_STATS_EN
    nCmp++;
    if ({sLuA, sMemA, sFlA, sLuB, sMemB, sFlB} !== 192'd0) begin
      nErr++; $display("FAIL stats_reset: got %h %h %h %h %h %h want 0",
                       sLuA, sMemA, sFlA, sLuB, sMemB, sFlB);
    end
`endif
    tick();
  endtask

  task automatic test_random();
    logic [15:0] exp;
    setIdle();
    nRST = 1'b0;
    tick();
    nRST = 1'b1;
    modelReset();
    for (int c = 0; c < 600; c++) begin
      ihit       = ($urandom_range(3) != 0);
      dhit       = ($urandom_range(4) > 1);
      memDmemREN = ($urandom_range(3) == 0);
      memDmemWEN = ($urandom_range(3) == 0);
      exDmemREN  = ($urandom_range(4) > 2);
      exWriteReg = 5'($urandom_range(3));
      idRs       = 5'($urandom_range(3));
      idRt       = 5'($urandom_range(3));
      idUsesRt   = 1'($urandom_range(1));
      exPcsrc    = ($urandom_range(6) == 0);
      @(negedge CLK);
      exp = {modelOut(0), modelOut(1)};
      nCmp++;
      if (obsAB() !== exp) begin
        nErr++; $display("FAIL random_c%0d: got %h want %h", c, obsAB(), exp);
      end
      @(posedge CLK);
      modelClock(0);
      modelClock(1);
      #1;
    end
    setIdle();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_reg_zero();
    test_mem_wait();
    test_branch();
    test_halt();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
